fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Instruction-fetch front end placed directly upstream of the decode/control datapath.
//   Owns the fetch PC, issues sequential word reads to a 1-cycle synchronous instruction memory,
//   and buffers returned words with their PC in a small queue. Decode drains it over valid/ready.
//   Branch/jump redirects flush the queue and discard in-flight data.
// PARAMETERS
//   DEPTH     4         queue entries (power of 2, >=2)
//   RESET_PC  32'h0     fetch PC loaded on reset
//   ADDR_W    32        PC / memory address width
// PORTS
//   clk             in   1       rising-edge clock
//   reset_n         in   1       synchronous, active-low reset
//   imem_req        out  1       read request this cycle
//   imem_addr       out  ADDR_W  byte address of request, [1:0]==2'b00
//   imem_rdata      in   32      word for request sampled on previous edge
//   redirect_valid  in   1       branch/jump taken; flush and refetch
//   redirect_pc     in   ADDR_W  target PC, bits [1:0] forced to 0
//   dec_valid       out  1       queue head valid
//   dec_instr       out  32      head instruction word
//   dec_pc          out  ADDR_W  head instruction PC
//   dec_pc4         out  ADDR_W  dec_pc + 4, modulo 2^ADDR_W
//   dec_ready       in   1       decode accepts head this cycle
// BEHAVIOUR
//   - Reset (reset_n==0 at edge): pc=RESET_PC, queue empty, inflight=0, imem_req=0,
//     imem_addr=0, dec_valid=0, dec_instr/dec_pc/dec_pc4 = 0.
//   - imem_req/imem_addr are registered. A request is issued when count+inflight < DEPTH and no
//     redirect this cycle; on issue pc<=pc+4 (wraps 32'hFFFFFFFC->0).
//   - Response: imem_rdata is valid exactly one cycle after imem_req; it is written into the queue
//     with its PC unless killed. The credit rule guarantees no overflow; drop never occurs.
//   - Handshake: transfer when dec_valid&&dec_ready. dec_* held stable while dec_valid&&!dec_ready.
//     dec_valid is combinational from queue occupancy only (no path from dec_ready).
//   - Simultaneous enqueue+dequeue when full or empty is legal; count unchanged when full.
//   - Latency: first edge with reset_n==1 -> imem_req=1 next cycle; word written one edge later;
//     dec_valid=1 three cycles after reset release. Steady-state throughput 1 instr/cycle.
//   - Redirect (priority over everything except reset): at that edge queue emptied, in-flight
//     response marked killed, pc<=redirect_pc. dec_valid=0 the following cycle even if dec_ready.
//     Request at redirect_pc issued the following cycle; first redirected dec_valid 3 cycles later.
//   - Redirect in consecutive cycles: last one wins; earlier targets never reach decode.
//   - reset_n low mid-stream: same as reset, in-flight response discarded.
//   - FSM (2 states): RUN (issuing/draining) and REFILL (one cycle after redirect, kill flag set);
//     REFILL->RUN unconditionally unless another redirect arrives.
// STRUCTURE
//   - Shared include mips_defs.vh: INSTR_W=32, WORD_BYTES=4, RESET_PC default, NOP=32'h0.
//   - Sub-module fetch_fifo: synchronous DEPTH x (32+ADDR_W) FIFO with flush, count,
//     wr_en/rd_en, head read combinational. Top holds pc, credit counter, kill flag, FSM.
// TESTING
//   1 Reset release, imem returns mem[i]=32'h2000_0000+i, dec_ready=1 -> dec_pc 0,4,8,... one per
//     cycle, first dec_valid 3 cycles after release, dec_pc4 = dec_pc+4.
//   2 dec_ready=0 for 10 cycles -> exactly DEPTH=4 entries held, imem_req deasserts, head stable
//     (pc 0, instr 32'h2000_0000); raise dec_ready -> 0,4,8,12,16 in order, no gaps after refill.
//   3 redirect_valid with redirect_pc=32'h40 while 3 entries queued + 1 in flight -> dec_valid=0
//     next cycle, no stale word delivered, next dec_pc=32'h40.
//   4 Redirects to 32'h80 then 32'hC0 on consecutive cycles -> first delivered dec_pc=32'hC0.
//   5 redirect_pc=32'hFFFF_FFFA -> imem_addr 32'hFFFF_FFF8, then 32'hFFFF_FFFC, then 32'h0.
//   6 reset_n low one cycle with queue full -> dec_valid=0, outputs 0, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   INSTR_W          instruction word width
//   WORD_BYTES       bytes per instruction word (PC step)
//   RESET_PC_DEFAULT default fetch PC after reset
//   NOP              value driven on dec_instr while no instruction is presented
//   fetch_state_e    fetch FSM states
package fetch_queue_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    // StRefill lasts one cycle after a redirect; the response arriving then is stale.
    typedef enum logic {
        StRun    = 1'b0,
        StRefill = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; head word is read combinationally.
//   clk_i      clock
//   rst_ni     synchronous active-low reset (empties the FIFO)
//   flush_i    empty the FIFO at this edge; overrides write and read
//   wr_en_i    push wr_data_i (accepted when not full, or when full and popping)
//   wr_data_i  entry to push
//   rd_en_i    pop the head (ignored when empty)
//   rd_data_o  head entry
//   empty_o    FIFO holds no entries
//   count_o    number of entries held
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty_o   = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        do_rd    = rd_en_i && !empty_o && !flush_i;
        do_wr    = wr_en_i && (!full || do_rd) && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_wr && !do_rd) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_wr && do_rd) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues sequential word reads to a
// 1-cycle synchronous instruction memory and buffers returned words with their PC.
//   clk             rising-edge clock
//   reset_n         synchronous active-low reset
//   imem_req        registered read request
//   imem_addr       registered word-aligned byte address of the request
//   imem_rdata      word for the request sampled on the previous edge
//   redirect_valid  taken branch/jump: flush the queue and refetch
//   redirect_pc     redirect target (bits [1:0] ignored)
//   dec_valid       queue head valid
//   dec_instr       head instruction word (NOP when not valid)
//   dec_pc          head PC (0 when not valid)
//   dec_pc4         head PC + 4 (0 when not valid)
//   dec_ready       decode accepts the head this cycle
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [ADDR_W-1:0]  dec_pc4,
    input  logic               dec_ready
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(WORD_BYTES);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_wr;
    logic               fifo_rd;
    logic               resp_live;
    logic [OCC_W-1:0]   occupancy;
    logic               issue;
    logic [ADDR_W-1:0]  redirect_target;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;

    assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

    // The word on imem_rdata during StRefill belongs to a request made before the redirect.
    assign resp_live = resp_valid_q && (state_q == StRun);

    // Credit: every queued entry plus every outstanding request reserves a slot,
    // so a returning word always finds room.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(req_q) + OCC_W'(resp_live);
    assign issue     = !redirect_valid && (occupancy < OCC_W'(DEPTH));

    assign fifo_wr   = resp_live && !redirect_valid;
    assign fifo_rd   = dec_valid && dec_ready;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .flush_i   (redirect_valid),
        .wr_en_i   (fifo_wr),
        .wr_data_i ({imem_rdata, resp_pc_q}),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_head),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign head_instr = fifo_head[ENTRY_W-1:ADDR_W];
    assign head_pc    = fifo_head[ADDR_W-1:0];

    // dec_valid depends on occupancy only, never on dec_ready.
    assign dec_valid  = !fifo_empty;
    assign dec_instr  = dec_valid ? head_instr : NOP;
    assign dec_pc     = dec_valid ? head_pc : '0;
    assign dec_pc4    = dec_valid ? (head_pc + PC_STEP) : '0;

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;

    always_comb begin
        state_d      = StRun;
        pc_d         = pc_q;
        req_d        = 1'b0;
        addr_d       = addr_q;
        resp_valid_d = req_q;
        resp_pc_d    = addr_q;

        unique case (state_q)
            StRun:    state_d = redirect_valid ? StRefill : StRun;
            StRefill: state_d = redirect_valid ? StRefill : StRun;
            default:  state_d = StRun;
        endcase

        if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (issue) begin
            req_d  = 1'b1;
            addr_d = pc_q;
            pc_d   = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a cycle table for the reset/startup timing, then
// hand-written sequences for back-pressure, redirects, PC wrap and mid-stream reset.
// A scoreboard of expected {pc, instr, pc4} records is loaded whenever reset or a redirect
// is driven and popped on every decode handshake.
module tb_fetch_queue;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc4;
    logic        dec_ready;

    fetch_queue dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_pc4        (dec_pc4),
        .dec_ready      (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle synchronous memory: mem[i] = 0x2000_0000 + i.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'h2000_0000 + (imem_addr >> 2);
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_xfer   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic expect_stream(input logic [31:0] start);
        logic [31:0] p;
        p = start;
        sb_q.delete();
        for (int i = 0; i < 64; i++) begin
            sb_q.push_back('{pc: p, instr: 32'h2000_0000 + (p >> 2), pc4: p + 32'd4});
            p = p + 32'd4;
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (reset_n && !redirect_valid && dec_valid && dec_ready) begin
            n_xfer++;
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_extra: got pc %h, required no transfer", dec_pc);
            end else begin
                e = sb_q.pop_front();
                if (dec_pc === e.pc && dec_instr === e.instr && dec_pc4 === e.pc4) n_pass++;
                else $display("FAIL sb_order: got pc/instr/pc4 %h/%h/%h, required %h/%h/%h",
                              dec_pc, dec_instr, dec_pc4, e.pc, e.instr, e.pc4);
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    // Ends at the negedge where dec_valid is seen (already monitored).
    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            sample();
            if (dec_valid) seen = 1'b1;
            else advance();
        end
        n_checks++;
        if (seen) n_pass++;
        else $display("FAIL %s: dec_valid got 0 for 12 cycles, required 1", name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          x0;
        int          n_req;
        logic [31:0] got [3];

        // Startup timing table: reset cycle, release, then one instruction per cycle.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0,         32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0,         32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0, 32'h0,         32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0, 32'h0,         32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0, 32'h2000_0000, 32'h4};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4, 32'h2000_0001, 32'h8};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 32'h2000_0002, 32'hC};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC, 32'h2000_0003, 32'h10};

        reset_n        = 1'b0;
        dec_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        expect_stream(32'h0);
        advance();

        // Test 1: reset release and streaming.
        for (int i = 0; i < 8; i++) begin
            reset_n   = vecs[i].rst_n;
            dec_ready = vecs[i].ready;
            @(negedge clk);
            chk($sformatf("t1_req[%0d]", i),   32'(imem_req),  32'(vecs[i].req));
            chk($sformatf("t1_addr[%0d]", i),  imem_addr,      vecs[i].addr);
            chk($sformatf("t1_valid[%0d]", i), 32'(dec_valid), 32'(vecs[i].valid));
            chk($sformatf("t1_pc[%0d]", i),    dec_pc,         vecs[i].pc);
            chk($sformatf("t1_instr[%0d]", i), dec_instr,      vecs[i].instr);
            chk($sformatf("t1_pc4[%0d]", i),   dec_pc4,        vecs[i].pc4);
            monitor();
            advance();
        end

        // Test 2: back-pressure fills the queue, then drains without gaps.
        reset_n   = 1'b0;
        dec_ready = 1'b0;
        expect_stream(32'h0);
        cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (i >= 6) begin
                chk($sformatf("t2_hold_pc[%0d]", i),  dec_pc,        32'h0);
                chk($sformatf("t2_hold_req[%0d]", i), 32'(imem_req), 32'h0);
            end
            advance();
        end
        sample();
        chk("t2_head_valid", 32'(dec_valid), 32'h1);
        chk("t2_head_instr", dec_instr,      32'h2000_0000);
        advance();
        dec_ready = 1'b1;
        x0 = n_xfer;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk($sformatf("t2_drain_valid[%0d]", i), 32'(dec_valid), 32'h1);
            advance();
        end
        chk("t2_drain_count", 32'(n_xfer - x0), 32'd5);

        // Test 3: redirect with entries queued and a word in flight.
        cycle();
        cycle();
        dec_ready = 1'b0;
        cycle();
        cycle();
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        expect_stream(32'h40);
        cycle();
        redirect_valid = 1'b0;
        sample();
        chk("t3_flush_valid", 32'(dec_valid), 32'h0);
        advance();
        x0 = n_xfer;
        wait_valid("t3_refill");
        chk("t3_first_pc", dec_pc, 32'h40);
        advance();
        cycle();
        cycle();
        cycle();
        chk("t3_xfer_count", 32'(n_xfer - x0), 32'd4);

        // Test 4: back-to-back redirects, the later target wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        expect_stream(32'h80);
        cycle();
        redirect_pc = 32'hC0;
        expect_stream(32'hC0);
        cycle();
        redirect_valid = 1'b0;
        x0 = n_xfer;
        wait_valid("t4_refill");
        chk("t4_first_pc", dec_pc, 32'hC0);
        advance();
        cycle();
        cycle();
        chk("t4_xfer_count", 32'(n_xfer - x0), 32'd3);

        // Test 5: unaligned target near the top of the address space wraps to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFA;
        expect_stream(32'hFFFF_FFF8);
        cycle();
        redirect_valid = 1'b0;
        n_req = 0;
        for (int i = 0; i < 3; i++) got[i] = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (imem_req && n_req < 3) begin
                got[n_req] = imem_addr;
                n_req++;
            end
            advance();
        end
        chk("t5_req_count", 32'(n_req), 32'd3);
        chk("t5_addr0", got[0], 32'hFFFF_FFF8);
        chk("t5_addr1", got[1], 32'hFFFF_FFFC);
        chk("t5_addr2", got[2], 32'h0000_0000);

        // Test 6: reset while the queue is full.
        dec_ready = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        reset_n   = 1'b0;
        dec_ready = 1'b1;
        expect_stream(32'h0);
        cycle();
        reset_n = 1'b1;
        sample();
        chk("t6_valid", 32'(dec_valid), 32'h0);
        chk("t6_instr", dec_instr,      32'h0);
        chk("t6_pc",    dec_pc,         32'h0);
        chk("t6_pc4",   dec_pc4,        32'h0);
        chk("t6_req",   32'(imem_req),  32'h0);
        chk("t6_addr",  imem_addr,      32'h0);
        advance();
        wait_valid("t6_restart");
        chk("t6_first_pc", dec_pc, 32'h0);
        advance();
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
